// File: rtl/eceg_scalar_mult_ctrl.sv
// Double-and-add sequencer for the shared ECEG point-arithmetic unit.
// Computes k*P left to right by issuing LOAD/DBL/ADD commands. A round-robin
// arbiter picks between the encrypt and decrypt requesters. No point data
// is held here.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module eceg_scalar_mult_ctrl #(
  parameter int unsigned DATAWIDTH = `DATAWIDTH,
  parameter int unsigned SCALAR_W  = DATAWIDTH,
  parameter int unsigned IDX_W     = (SCALAR_W > 1) ? $clog2(SCALAR_W) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_enc,
  input  logic [SCALAR_W-1:0] k_enc,
  input  logic                req_dec,
  input  logic [SCALAR_W-1:0] k_dec,
  output logic                gnt_enc,
  output logic                gnt_dec,
  output logic                op_valid,
  output logic [1:0]          op_code,
  input  logic                op_ready,
  input  logic                op_done,
  output logic                busy,
  output logic                done,
  output logic                done_owner,
  output logic                res_inf,
  output logic [IDX_W-1:0]    bit_idx
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_DBL  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SCALAR_W-1:0] kreg_q, kreg_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;

  logic                gnt_enc_d, gnt_dec_d;
  logic                op_valid_d;
  logic [1:0]          op_code_d;
  logic                busy_d, done_d, done_owner_d, res_inf_d;
  logic [IDX_W-1:0]    bit_idx_d;

  logic                winner_c;
  logic                kbit_c;

  // Current scalar bit under inspection.
  assign kbit_c = kreg_q[bit_idx];

  // State and registered outputs; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      kreg_q       <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      gnt_enc      <= 1'b0;
      gnt_dec      <= 1'b0;
      op_valid     <= 1'b0;
      op_code      <= OP_LOAD;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_owner   <= 1'b0;
      res_inf      <= 1'b0;
      bit_idx      <= '0;
    end else begin
      state_q      <= state_d;
      kreg_q       <= kreg_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_enc      <= gnt_enc_d;
      gnt_dec      <= gnt_dec_d;
      op_valid     <= op_valid_d;
      op_code      <= op_code_d;
      busy         <= busy_d;
      done         <= done_d;
      done_owner   <= done_owner_d;
      res_inf      <= res_inf_d;
      bit_idx      <= bit_idx_d;
    end
  end

  // Next state, arbitration and command selection.
  always_comb begin
    state_d      = state_q;
    kreg_d       = kreg_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_enc_d    = 1'b0;
    gnt_dec_d    = 1'b0;
    op_valid_d   = op_valid;
    op_code_d    = op_code;
    busy_d       = busy;
    done_d       = 1'b0;
    done_owner_d = done_owner;
    res_inf_d    = res_inf;
    bit_idx_d    = bit_idx;

    // On a tie the requester that was not served last wins.
    winner_c = (req_enc && req_dec) ? ~last_owner_q : req_dec;

    case (state_q)
      S_IDLE: begin
        if (req_enc || req_dec) begin
          state_d      = S_GRANT;
          gnt_enc_d    = ~winner_c;
          gnt_dec_d    = winner_c;
          owner_d      = winner_c;
          last_owner_d = winner_c;
          busy_d       = 1'b1;
        end
      end

      // The grant pulse is visible now, so the scalar is taken this cycle.
      S_GRANT: begin
        kreg_d    = owner_q ? k_dec : k_enc;
        bit_idx_d = IDX_W'(SCALAR_W - 1);
        state_d   = S_SCAN;
      end

      S_SCAN: begin
        if (kbit_c) begin
          op_valid_d = 1'b1;
          op_code_d  = OP_LOAD;
          state_d    = S_ISSUE;
        end else if (bit_idx == '0) begin
          res_inf_d    = 1'b1;
          done_d       = 1'b1;
          done_owner_d = owner_q;
          state_d      = S_DONE;
        end else begin
          bit_idx_d = bit_idx - IDX_W'(1);
        end
      end

      S_ISSUE: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (op_done) begin
          state_d = S_NEXT;
        end
      end

      // op_code still holds the command that just completed.
      S_NEXT: begin
        if ((op_code == OP_DBL) && kbit_c) begin
          op_valid_d = 1'b1;
          op_code_d  = OP_ADD;
          state_d    = S_ISSUE;
        end else if (bit_idx == '0) begin
          res_inf_d    = 1'b0;
          done_d       = 1'b1;
          done_owner_d = owner_q;
          state_d      = S_DONE;
        end else begin
          bit_idx_d  = bit_idx - IDX_W'(1);
          op_valid_d = 1'b1;
          op_code_d  = OP_DBL;
          state_d    = S_ISSUE;
        end
      end

      S_DONE: begin
        busy_d       = 1'b0;
        done_owner_d = 1'b0;
        res_inf_d    = 1'b0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_eceg_scalar_mult_ctrl.sv
// Self-checking bench for eceg_scalar_mult_ctrl with a 4-bit scalar and a
// point-unit model that completes each command 3 cycles after issue.
module tb_eceg_scalar_mult_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_enc, req_dec;
  logic [3:0] k_enc, k_dec;
  logic       gnt_enc, gnt_dec;
  logic       op_valid;
  logic [1:0] op_code;
  logic       op_ready;
  logic       op_done;
  logic       busy, done, done_owner, res_inf;
  logic [1:0] bit_idx;

  logic       spur;
  logic [2:0] pipe;

  int n_tests = 0;
  int n_fail  = 0;
  int issue_cnt = 0;
  int done_cnt  = 0;
  logic m_last = 1'b1;

  logic [1:0] exp_ops[$];
  logic [1:0] exp_done[$];

  logic [10:0] outs;
  assign outs = {gnt_enc, gnt_dec, op_valid, op_code, busy, done, done_owner, res_inf, bit_idx};

  eceg_scalar_mult_ctrl #(
    .DATAWIDTH(4),
    .SCALAR_W (4),
    .IDX_W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_enc   (req_enc),
    .k_enc     (k_enc),
    .req_dec   (req_dec),
    .k_dec     (k_dec),
    .gnt_enc   (gnt_enc),
    .gnt_dec   (gnt_dec),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .op_ready  (op_ready),
    .op_done   (op_done),
    .busy      (busy),
    .done      (done),
    .done_owner(done_owner),
    .res_inf   (res_inf),
    .bit_idx   (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Point unit: completion pulse 3 cycles after each issue; reset with the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[1:0], op_valid & op_ready};
  end
  assign op_done = pipe[2] | spur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference double-and-add command list for scalar k.
  task automatic push_job(input logic own, input logic [3:0] k);
    int m;
    m = -1;
    for (int i = 3; i >= 0; i--) if (k[i] && m < 0) m = i;
    if (m >= 0) begin
      exp_ops.push_back(2'b00);
      for (int i = m - 1; i >= 0; i--) begin
        exp_ops.push_back(2'b01);
        if (k[i]) exp_ops.push_back(2'b10);
      end
    end
    exp_done.push_back({own, (m < 0) ? 1'b1 : 1'b0});
  endtask

  // Scoreboard monitor: push on grant, pop on issue and on done.
  initial begin : mon
    logic w;
    logic [1:0] e, d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (gnt_enc || gnt_dec) begin
          w = (req_enc && req_dec) ? ~m_last : req_dec;
          check("arb_winner", 32'({gnt_enc, gnt_dec}), w ? 32'd1 : 32'd2);
          push_job(w, w ? k_dec : k_enc);
          m_last = w;
        end
        if (op_valid && op_ready) begin
          issue_cnt++;
          if (exp_ops.size() == 0) check("op_extra", 32'(op_code), 32'hff);
          else begin
            e = exp_ops.pop_front();
            check("op_seq", 32'(op_code), 32'(e));
          end
        end
        if (done) begin
          done_cnt++;
          check("done_leftover_ops", 32'(exp_ops.size()), 32'd0);
          if (exp_done.size() == 0) check("done_extra", 32'(done_owner), 32'hff);
          else begin
            d = exp_done.pop_front();
            check("done_owner", 32'(done_owner), 32'(d[1]));
            check("res_inf", 32'(res_inf), 32'(d[0]));
          end
        end
      end
    end
  end

  task automatic wait_gnt();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = gnt_enc | gnt_dec;
    end
    check("gnt_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = op_valid;
    end
  endtask

  // One job from a single requester; k is scrambled after the grant.
  task automatic run_job(input logic who, input logic [3:0] k, input int nops, input logic inf);
    issue_cnt = 0;
    if (who) begin req_dec = 1'b1; k_dec = k; end
    else     begin req_enc = 1'b1; k_enc = k; end
    wait_gnt();
    check("busy_at_gnt", 32'(busy), 32'd1);
    @(posedge clk); #1;
    if (who) begin req_dec = 1'b0; k_dec = ~k; end
    else     begin req_enc = 1'b0; k_enc = ~k; end
    wait_done();
    check("tbl_res_inf", 32'(res_inf), 32'(inf));
    check("tbl_n_ops", 32'(issue_cnt), 32'(nops));
    @(negedge clk);
    check("busy_after_done", 32'({busy, done}), 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       who;
    logic [3:0] k;
    int         nops;
    logic       inf;
  } vec_t;

  vec_t tbl[7];

  initial begin : main
    bit seen;
    int cyc;
    int dcnt0;

    tbl[0] = '{1'b0, 4'b0101, 4, 1'b0};
    tbl[1] = '{1'b1, 4'b0000, 0, 1'b1};
    tbl[2] = '{1'b0, 4'b1111, 7, 1'b0};
    tbl[3] = '{1'b1, 4'b1000, 4, 1'b0};
    tbl[4] = '{1'b0, 4'b0001, 1, 1'b0};
    tbl[5] = '{1'b1, 4'b1010, 5, 1'b0};
    tbl[6] = '{1'b0, 4'b0110, 4, 1'b0};

    rst_n = 1'b0; req_enc = 1'b0; req_dec = 1'b0;
    k_enc = '0; k_dec = '0; op_ready = 1'b1; spur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_job(tbl[i].who, tbl[i].k, tbl[i].nops, tbl[i].inf);

    // Zero scalar: no commands, done five cycles after the grant.
    issue_cnt = 0;
    req_dec = 1'b1; k_dec = 4'b0000;
    wait_gnt();
    @(posedge clk); #1;
    req_dec = 1'b0;
    cyc = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      cyc++;
      seen = done;
    end
    check("inf_latency", 32'(cyc), 32'd5);
    check("inf_no_ops", 32'(issue_cnt), 32'd0);
    @(posedge clk); #1;

    // Contention: enc first, dec next, enc re-request served after dec.
    issue_cnt = 0;
    req_enc = 1'b1; k_enc = 4'b0001; req_dec = 1'b1; k_dec = 4'b1000;
    wait_gnt();
    check("t3_first_enc", 32'({gnt_enc, gnt_dec}), 32'd2);
    @(posedge clk); #1;
    k_enc = 4'b0010;
    wait_done();
    wait_gnt();
    check("t3_second_dec", 32'({gnt_enc, gnt_dec}), 32'd1);
    @(posedge clk); #1;
    req_dec = 1'b0;
    wait_done();
    wait_gnt();
    check("t3_third_enc", 32'({gnt_enc, gnt_dec}), 32'd2);
    @(posedge clk); #1;
    req_enc = 1'b0;
    wait_done();
    check("t3_n_ops", 32'(issue_cnt), 32'd7);
    @(posedge clk); #1;

    // Backpressure on the first DBL.
    issue_cnt = 0;
    req_enc = 1'b1; k_enc = 4'b0101;
    wait_gnt();
    @(posedge clk); #1;
    req_enc = 1'b0;
    wait_valid(seen);
    check("t4_load_seen", 32'({seen, op_code}), 32'h4);
    @(posedge clk); #1;
    op_ready = 1'b0;
    wait_valid(seen);
    check("t4_dbl_seen", 32'({seen, op_code}), 32'h5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4_stall", 32'({op_valid, op_code}), 32'h5);
    end
    check("t4_no_issue", 32'(issue_cnt), 32'd1);
    @(posedge clk); #1;
    op_ready = 1'b1;
    wait_done();
    check("t4_n_ops", 32'(issue_cnt), 32'd4);
    @(posedge clk); #1;

    // Reset in the WAIT of the second command.
    issue_cnt = 0;
    req_enc = 1'b1; k_enc = 4'b1111;
    wait_gnt();
    @(posedge clk); #1;
    req_enc = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = op_valid && op_ready && (op_code == 2'b01);
    end
    check("t5_dbl_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    check("t5_busy_before", 32'({busy, op_valid}), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_async_reset", 32'(outs), 32'd0);
    exp_ops.delete();
    exp_done.delete();
    m_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(1'b0, 4'b0011, 3, 1'b0);

    // Spurious op_done in IDLE.
    dcnt0 = done_cnt;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_idle", 32'({busy, op_valid, done}), 32'd0);
    end
    check("t6_idle_no_done", 32'(done_cnt), 32'(dcnt0));

    // Spurious op_done in SCAN.
    issue_cnt = 0;
    req_enc = 1'b1; k_enc = 4'b0001;
    wait_gnt();
    @(posedge clk); #1;
    req_enc = 1'b0;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    check("t6_scan", 32'({busy, op_valid, done, bit_idx}), 32'h12);
    wait_done();
    check("t6_n_ops", 32'(issue_cnt), 32'd1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
